// File: rtl/seg7_scan_if.sv
// Bus between the display register and the seven-segment scan controller.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    frame_done;
  logic                    upd_pending;

  modport master (
    output enable, load, value_in,
    input  an, seg, frame_done, upd_pending
  );

  modport slave (
    input  enable, load, value_in,
    output an, seg, frame_done, upd_pending
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan of a common-anode 7-segment bank with blanking gap and double-buffered value.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         pending;
  logic [DW-1:0]         active;
  logic                  flag;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  fd_q;

  logic                  slot_end;
  logic                  wrap;
  logic                  boundary;
  logic                  show_digit;
  logic                  drive;
  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg7_decode = 7'h40;
      4'h1:    seg7_decode = 7'h79;
      4'h2:    seg7_decode = 7'h24;
      4'h3:    seg7_decode = 7'h30;
      4'h4:    seg7_decode = 7'h19;
      4'h5:    seg7_decode = 7'h12;
      4'h6:    seg7_decode = 7'h02;
      4'h7:    seg7_decode = 7'h78;
      4'h8:    seg7_decode = 7'h00;
      4'h9:    seg7_decode = 7'h10;
      4'hA:    seg7_decode = 7'h08;
      4'hB:    seg7_decode = 7'h03;
      4'hC:    seg7_decode = 7'h46;
      4'hD:    seg7_decode = 7'h21;
      4'hE:    seg7_decode = 7'h06;
      default: seg7_decode = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign wrap      = bus.enable && slot_end && (idx == IDX_LAST);
  // While disabled every cycle counts as a frame boundary, so updates are never held off.
  assign boundary  = wrap || !bus.enable;
  assign cur_digit = active[{idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  assign show_digit = (idx <= msd);
`else
  assign show_digit = 1'b1;
`endif

  assign drive = bus.enable && (cnt >= CNT_BLANK) && show_digit;

  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    if (drive) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = seg7_decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      idx     <= '0;
      pending <= '0;
      active  <= '0;
      flag    <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      fd_q    <= 1'b0;
    end else begin
      if (!bus.enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A load landing on the boundary bypasses the pending buffer entirely.
      if (bus.load && boundary) begin
        active <= bus.value_in;
        flag   <= 1'b0;
      end else if (bus.load) begin
        pending <= bus.value_in;
        flag    <= 1'b1;
      end else if (boundary && flag) begin
        active <= pending;
        flag   <= 1'b0;
      end

      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      fd_q  <= wrap;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_done  = fd_q;
  assign bus.upd_pending = flag;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's common-anode seven-segment display bank. It holds an N-digit hex value and cycles through the digits, driving one active-low anode at a time together with that digit's segment pattern. A blanking gap at the start of each digit slot suppresses ghosting. New values are double-buffered so a displayed frame never tears; the block sits between the processor's display register and the FPGA pins.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned (2..8).
- `REFRESH_DIV`, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all anodes off (≥1).

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: scan enable.
- `load` in 1: one-cycle strobe; capture `value_in` into the pending buffer.
- `value_in` in 4*NUM_DIGITS: hex digits; digit 0 = bits [3:0].
- `an` out NUM_DIGITS: anode drives, active-low one-hot (all ones = off). Registered.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low. Registered.
- `frame_done` out 1: one-cycle pulse when slot NUM_DIGITS-1 ends.
- `upd_pending` out 1: high while a loaded value awaits the next frame boundary.

## Operation
- State: prescaler `cnt` (0..REFRESH_DIV-1), slot index `idx` (0..NUM_DIGITS-1), `pending` buffer plus flag, `active` buffer.
- Reset: cnt=0, idx=0, pending=0, active=0, flag=0, an=all ones, seg=7'h7F, frame_done=0, upd_pending=0.
- Scan, when enable=1: cnt increments. At cnt==REFRESH_DIV-1, cnt→0 and idx advances; at idx==NUM_DIGITS-1 it wraps to 0 and asserts frame_done.
- Phase within slot: BLANK while cnt<BLANK_CYCLES (an=all ones, seg=7'h7F). DRIVE otherwise (an[idx]=0, others 1; seg=decode(active digit idx)).
- Decode (hex→seg): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- enable=0: cnt and idx forced to 0 on each clock; an=all ones and seg=7'h7F. Load and the buffer transfer still operate; transfer occurs on any cycle while disabled. Re-enabling starts at slot 0, cnt=0.
- Load: value_in goes into pending and the flag is set. A later load before the boundary overwrites pending (last wins).
- Frame boundary (wrap cycle, or any disabled cycle) with flag set: active←pending, flag cleared.
- Load in the boundary cycle itself: value_in goes straight to active and the flag stays clear.
- upd_pending equals the flag.
- Reset mid-frame: everything returns to reset values on the next edge. A pending update is discarded.

## Timing
- an/seg are registered and reflect the cnt/idx/active state from the preceding cycle (1-cycle latency).
- The first DRIVE cycle on the pins is cycle BLANK_CYCLES+1 after the slot starts.
- frame_done is high in the cycle after the wrap edge and lasts exactly 1 cycle.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- A load takes effect on the pins no earlier than the first DRIVE cycle of slot 0 of the next frame. Worst-case delay is one frame plus BLANK_CYCLES+1 cycles.
- upd_pending rises on the edge after load and falls on the boundary edge.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking. Digits above the most significant nonzero digit of active are blanked for their whole slot (an all ones, seg=7'h7F). Digit 0 is always shown, so an all-zero value displays "0".
- `SEG7_LZB_EN` undefined: all NUM_DIGITS digits are always driven.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then load 16'h12AF with enable=1: after the boundary, slots 0..3 drive an=1110/1101/1011/0111 with seg=0E/08/24/79. Each slot shows 2 blank cycles then 6 drive cycles. frame_done pulses every 32 cycles.
- Loads 16'h1111 then 16'h2222 mid-frame: upd_pending=1. The display keeps the old value until the wrap, then shows 2222. 1111 never appears.
- Load coincident with the wrap cycle: new value visible in slot 0 of the very next frame, and upd_pending stays 0.
- Drop enable mid-slot 2: next cycle an=1111 and seg=7F. Re-enable: scanning restarts at slot 0 with cnt=0.
- Assert reset mid-slot with an update pending: outputs return to reset values, upd_pending=0, and the active value becomes 0.
- With SEG7_LZB_EN defined, load 16'h0050: slots 2 and 3 stay blank, slot 1 shows 12, slot 0 shows 40. Load 16'h0000: only slot 0 shows 40.
